fifo_echo_relay: RTL

//  Initiator-side client of the Fifo method interface. Drains words from an upstream Fifo

---
 rtl/fifo_relay_pkg.sv | 12 +
 rtl/fifo_echo_relay.sv | 83 ++++++++
 2 files changed

// File: rtl/fifo_relay_pkg.sv
// Shared types for the Fifo echo relay: FSM state encoding and data width.
package fifo_relay_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_echo_relay.sv
// Drains one word at a time from an upstream Fifo, holds it for DELAY cycles,
// then enqueues it (XOR-masked) downstream and counts completed transfers.
module fifo_echo_relay
    import fifo_relay_pkg::*;
#(
    parameter int              DELAY    = 2,
    parameter logic [DATA_W-1:0] XOR_MASK = 32'h00000000,
    parameter int              CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [DATA_W-1:0] in_first,
    input  logic              in_first__RDY,
    input  logic              in_deq__RDY,
    output logic              in_deq__ENA,
    input  logic              out_enq__RDY,
    output logic              out_enq__ENA,
    output logic [DATA_W-1:0] out_enq_v,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);

    localparam logic [7:0] DELAY_M1 = (DELAY == 0) ? 8'd0 : 8'(DELAY - 1);

    state_e            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              deq_fire, enq_fire;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
            count_q    <= count_d;
        end
    end

    // ENAs are gated by nRST so no method fires while reset is held.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        count_d    = count_q;
        deq_fire   = 1'b0;
        enq_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                deq_fire = nRST & in_first__RDY & in_deq__RDY;
                if (deq_fire) begin
                    data_d     = in_first;
                    wait_cnt_d = DELAY_M1;
                    state_d    = (DELAY == 0) ? SEND : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 8'd0) state_d = SEND;
                else                    wait_cnt_d = wait_cnt_q - 8'd1;
            end
            SEND: begin
                enq_fire = nRST & out_enq__RDY;
                if (enq_fire) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_deq__ENA  = deq_fire;
    assign out_enq__ENA = enq_fire;
    assign out_enq_v    = data_q ^ XOR_MASK;
    assign count        = count_q;
    assign busy         = (state_q != IDLE);

endmodule
